md_ctrl: RTL and testbench
==========================

# md_ctrl

Multiply/divide sequencer for the EX stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from EX with operands that are already forwarded, and holds the result invisible for a fixed multi-cycle latency. It owns the HI/LO registers and drives a stall request to the hazard unit whenever the instruction in ID needs the unit while it is occupied. It also supplies the mfhi/mflo read value to the EX result path.

## Interface
- MULT_LAT, 5, cycles busy for mult/multu
- DIV_LAT, 10, cycles busy for div/divu
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- start  in  1  EX holds a valid MD-class instruction this cycle
- mdOp  in  3  operation code (package enum): MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
- a  in  32  rs value after forwarding
- b  in  32  rt value after forwarding
- mdInId  in  1  instruction currently in ID is any MD-class op
- busy  out  1  multi-cycle operation in progress
- stall  out  1  stall request to hazard unit
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- mdOut  out  32  MFHI → hi, MFLO → lo, else 0 (combinational)

## Operation
- States: IDLE, RUN. Reset → IDLE, cnt=0, hi=0, lo=0, busy=0, pending regs=0.
- IDLE, start & mdOp∈{MULT,MULTU}: compute 64-bit product (signed/unsigned), latch into pendHi/pendLo, cnt←MULT_LAT, → RUN.
- IDLE, start & mdOp∈{DIV,DIVU}: latch quotient→pendLo, remainder→pendHi (signed: truncate toward zero, remainder takes sign of dividend), cnt←DIV_LAT, → RUN.
- Divide by zero: enter RUN for DIV_LAT cycles as normal; commit is suppressed, so hi/lo are unchanged.
- IDLE, start & MTHI: hi←a at edge; MTLO: lo←a. No busy, stays IDLE.
- MFHI/MFLO: read only, no state change; start is ignored for state purposes.
- RUN: cnt decrements each cycle; when cnt==1 at an edge, hi/lo←pend (unless div-by-zero flag), cnt←0, → IDLE.
- busy = (state==RUN).
- stall = mdInId & (busy | (start & mdOp∈{MULT,MULTU,DIV,DIVU})).
- start while RUN is a protocol violation, prevented by stall. Required response: ignore, state unaffected. Covered by bench assertion.
- INT_MIN / -1 signed: lo=0x80000000, hi=0, no trap.

## Timing
- Start sampled at edge E0. busy is high for exactly LAT cycles after E0. hi/lo take new values at edge E0+LAT. busy is low in the same cycle the new hi/lo are visible.
- Back-to-back: a new start is accepted in the first cycle busy is low.
- mdOut reflects the current hi/lo registers. An MFHI in EX during RUN cannot occur because stall held it in ID.
- MTHI/MTLO results are visible the cycle after E0.
- Reset during RUN: the next cycle is IDLE, hi=lo=0, and the pending result is discarded.
- Reset has priority over start.

## Structure
- Shared package (or header macros): mdOp encoding, state encoding, MULT_LAT/DIV_LAT defaults.
- Sub-module md_calc: combinational signed/unsigned 64-bit multiply and 32-bit divide/remainder with a div-by-zero flag. md_ctrl contains the FSM, counter, pending and HI/LO registers.
- The hazard unit ORs stall into its existing stall logic.

## Test plan
- MULT a=0xFFFFFFFF b=2 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3, hi=1.
- DIV by b=0 after MTHI 0x1234 / MTLO 0x5678 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
- MULT start with mdInId=1 (MFLO in ID) → stall high from the start cycle through the last busy cycle (6 cycles total); the next cycle MFLO sees the new lo via mdOut.
- reset at cycle 3 of DIV → next cycle busy=0, hi=lo=0; a subsequent MTLO 0xA5 gives lo=0xA5.
- INT_MIN/-1 signed DIV → lo=0x80000000, hi=0. A start asserted during RUN leaves cnt and the result unchanged.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
// Holds the MD op encoding, the FSM state encoding and the default latencies.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdDiv   = 3'd2,
    MdDivu  = 3'd3,
    MdMthi  = 3'd4,
    MdMtlo  = 3'd5,
    MdMfhi  = 3'd6,
    MdMflo  = 3'd7
  } md_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

  localparam int unsigned MultLatDefault = 5;
  localparam int unsigned DivLatDefault  = 10;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_long_op(md_op_e op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic is_signed_op(md_op_e op);
    return (op == MdMult) || (op == MdDiv);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 32x32 multiply and 32/32 divide, signed or unsigned.
// Division works on magnitudes, so INT_MIN / -1 wraps to INT_MIN with remainder 0.
module md_calc (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [63:0] prod_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        div_zero_o
);

  logic [63:0] a_ext, b_ext;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    a_ext = signed_i ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
    b_ext = signed_i ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
    // Low 64 bits of the sign-extended product are the exact signed result.
    prod_o = a_ext * b_ext;

    a_neg = signed_i & a_i[31];
    b_neg = signed_i & b_i[31];
    a_mag = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag = b_neg ? (~b_i + 32'd1) : b_i;

    div_zero_o = (b_i == 32'd0);
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (!div_zero_o) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end

    // Truncate toward zero; remainder follows the dividend's sign.
    quot_o = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem_o  = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for EX: owns HI/LO, hides results for a fixed latency
// and raises a stall when the instruction in ID needs the unit while it is occupied.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MultLatDefault,
  parameter int unsigned DIV_LAT  = DivLatDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      mdOp,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mdInId,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  md_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic        div_zero;

  md_calc u_calc (
    .a_i        (a),
    .b_i        (b),
    .signed_i   (is_signed_op(mdOp)),
    .prod_o     (prod),
    .quot_o     (quot),
    .rem_o      (rem),
    .div_zero_o (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (mdOp)
            MdMult, MdMultu: begin
              pend_hi_d = prod[63:32];
              pend_lo_d = prod[31:0];
              pend_dz_d = 1'b0;
              cnt_d     = CntW'(MULT_LAT);
              state_d   = StRun;
            end
            MdDiv, MdDivu: begin
              pend_hi_d = rem;
              pend_lo_d = quot;
              pend_dz_d = div_zero;
              cnt_d     = CntW'(DIV_LAT);
              state_d   = StRun;
            end
            MdMthi:  hi_d = a;
            MdMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        // A start seen here is a protocol violation and is deliberately ignored.
        if (cnt_q == CntW'(1)) begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    busy  = (state_q == StRun);
    stall = mdInId & (busy | (start & is_long_op(mdOp)));
    hi    = hi_q;
    lo    = lo_q;
    case (mdOp)
      MdMfhi:  mdOut = hi_q;
      MdMflo:  mdOut = lo_q;
      default: mdOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed cases then random traffic against
// a cycle-level reference model built from the arithmetic rules.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int MultLat = 5;
  localparam int DivLat  = 10;

  logic        clk = 1'b0;
  logic        reset, start, mdInId;
  md_op_e      mdOp;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo, mdOut;

  int checks   = 0;
  int failures = 0;

  // Reference model state: architectural HI/LO, cycles still busy, pending result.
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  logic        m_dz;
  int          m_rem;

  md_ctrl #(.MULT_LAT(MultLat), .DIV_LAT(DivLat)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdOp   (mdOp),
    .a      (a),
    .b      (b),
    .mdInId (mdInId),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo),
    .mdOut  (mdOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit long_op(md_op_e op);
    return op == MdMult || op == MdMultu || op == MdDiv || op == MdDivu;
  endfunction

  task automatic model_edge(input logic r, input logic s, input md_op_e op,
                            input logic [31:0] av, input logic [31:0] bv);
    int     sa, sb;
    longint sp;
    longint unsigned up;
    sa = av;
    sb = bv;
    if (r) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_dz = 0; m_ph = 0; m_pl = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && !m_dz) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end else if (s) begin
      case (op)
        MdMult: begin
          sp = longint'(sa) * longint'(sb);
          m_ph = sp[63:32]; m_pl = sp[31:0]; m_dz = 0; m_rem = MultLat;
        end
        MdMultu: begin
          up = longint'({32'b0, av}) * longint'({32'b0, bv});
          m_ph = up[63:32]; m_pl = up[31:0]; m_dz = 0; m_rem = MultLat;
        end
        MdDiv: begin
          m_dz = (bv == 0);
          m_rem = DivLat;
          if (bv == 0) begin
            m_ph = 0; m_pl = 0;
          end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            m_pl = 32'h8000_0000; m_ph = 0;
          end else begin
            m_pl = sa / sb; m_ph = sa % sb;
          end
        end
        MdDivu: begin
          m_dz = (bv == 0);
          m_rem = DivLat;
          if (bv != 0) begin
            m_pl = av / bv; m_ph = av % bv;
          end
        end
        MdMthi: m_hi = av;
        MdMtlo: m_lo = av;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle, compare all outputs before the edge, then advance model and DUT.
  task automatic cyc(input logic r, input logic s, input md_op_e op,
                     input logic [31:0] av, input logic [31:0] bv, input logic inid);
    logic exp_busy, exp_stall;
    logic [31:0] exp_out;
    reset = r; start = s; mdOp = op; a = av; b = bv; mdInId = inid;
    #1;
    exp_busy  = (m_rem > 0);
    exp_stall = inid && (exp_busy || (s && long_op(op)));
    exp_out   = (op == MdMfhi) ? m_hi : (op == MdMflo) ? m_lo : 32'd0;
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("mdOut", mdOut, exp_out);
    model_edge(r, s, op, av, bv);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input md_op_e op, input logic inid);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, op, 32'd0, 32'd0, inid);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; mdOp = MdMfhi; a = 0; b = 0; mdInId = 1'b0;
    @(posedge clk);
    #1;
    model_edge(1'b1, 1'b0, MdMfhi, 0, 0);

    // Reset state.
    idle(1, MdMfhi, 1'b1);

    cyc(0, 1, MdMult, 32'hFFFF_FFFF, 32'd2, 0);
    idle(MultLat, MdMfhi, 0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    chk("mult_busy_low", {31'b0, busy}, 32'd0);

    cyc(0, 1, MdMultu, 32'hFFFF_FFFF, 32'd2, 0);
    idle(MultLat, MdMflo, 0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    cyc(0, 1, MdDiv, 32'hFFFF_FFF9, 32'd2, 0);
    idle(DivLat, MdMfhi, 0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    cyc(0, 1, MdDivu, 32'd7, 32'd2, 0);
    idle(DivLat, MdMfhi, 0);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    cyc(0, 1, MdMthi, 32'h1234, 32'd0, 0);
    chk("mthi_vis", hi, 32'h1234);
    cyc(0, 1, MdMtlo, 32'h5678, 32'd0, 0);
    chk("mtlo_vis", lo, 32'h5678);
    cyc(0, 1, MdDiv, 32'd5, 32'd0, 0);
    idle(DivLat, MdMfhi, 0);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'h5678);

    // MULT with MFLO waiting in ID: stall on start cycle and every busy cycle.
    cyc(0, 1, MdMult, 32'd3, 32'd4, 1);
    idle(MultLat, MdMflo, 1);
    chk("mflo_after_stall", mdOut, 32'd12);
    chk("stall_released", {31'b0, stall}, 32'd0);
    idle(1, MdMflo, 1);

    // Reset in the third cycle of a divide.
    cyc(0, 1, MdDiv, 32'd100, 32'd3, 0);
    idle(2, MdMfhi, 0);
    cyc(1, 0, MdMfhi, 32'd0, 32'd0, 0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    cyc(0, 1, MdMtlo, 32'hA5, 32'd0, 0);
    chk("post_rst_mtlo", lo, 32'hA5);

    // INT_MIN / -1, with illegal starts injected while running.
    cyc(0, 1, MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    cyc(0, 1, MdMthi, 32'hDEAD_BEEF, 32'd0, 0);
    cyc(0, 1, MdMult, 32'd9, 32'd9, 0);
    idle(DivLat - 2, MdMflo, 0);
    chk("intmin_lo", lo, 32'h8000_0000);
    chk("intmin_hi", hi, 32'd0);

    // Random traffic, including occasional resets and starts during RUN.
    for (int i = 0; i < 3000; i++) begin
      logic rr, ss;
      rr = ($urandom_range(0, 63) == 0);
      ss = ($urandom_range(0, 2) != 0);
      cyc(rr, ss, md_op_e'($urandom_range(0, 7)), pick_operand(), pick_operand(),
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
